// File: rtl/jelly3_img_bayer_pkg.sv
// ---------------------------------------------------------------------------
// jelly3_img_bayer_pkg
//   Shared Bayer definitions for the mosaic (RGB -> raw) and demosaic
//   (raw -> RGB) blocks.
//
//   phase_t : 2-bit Bayer phase of a pixel.
//             bit0 = column parity, bit1 = row parity.
//   PHASE_R  = 00 : red site
//   PHASE_GR = 01 : green site on a red row
//   PHASE_GB = 10 : green site on a blue row
//   PHASE_B  = 11 : blue site
// ---------------------------------------------------------------------------
package jelly3_img_bayer_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PHASE_R  = 2'b00;
    localparam phase_t PHASE_GR = 2'b01;
    localparam phase_t PHASE_GB = 2'b10;
    localparam phase_t PHASE_B  = 2'b11;

    // True when the phase addresses one of the two green sites.
    function automatic logic is_green_site(input phase_t ph);
        return ph[0] ^ ph[1];
    endfunction

endpackage

// File: rtl/jelly3_img_bayer_phase_counter.sv
// ---------------------------------------------------------------------------
// jelly3_img_bayer_phase_counter
//   Tracks the Bayer phase of the pixel currently presented on the input.
//   The phase output is combinational for the current input pixel; the
//   internal state only advances on accepted pixels (cke & valid).
//
//   Frame start (line_first & pixel_first): phase = param_phase, and
//     param_phase is latched as the held frame phase.
//   Line start (pixel_first only): column parity restarts from the held
//     phase, row parity toggles.
//   Any other accepted pixel: column parity toggles.
//   Before any frame start since reset the held phase is PHASE_R.
//
// Ports
//   reset_n     in  async active-low reset
//   clk         in  clock, rising edge
//   cke         in  clock enable
//   valid       in  input pixel valid
//   line_first  in  first pixel of a frame (with pixel_first)
//   pixel_first in  first pixel of a line
//   param_phase in  phase of the top-left pixel of a frame
//   phase       out phase of the current input pixel
// ---------------------------------------------------------------------------
module jelly3_img_bayer_phase_counter
    import jelly3_img_bayer_pkg::*;
(
    input  logic   reset_n,
    input  logic   clk,
    input  logic   cke,
    input  logic   valid,
    input  logic   line_first,
    input  logic   pixel_first,
    input  phase_t param_phase,
    output phase_t phase
);

    phase_t r_held;     // phase of the top-left pixel of the current frame
    phase_t r_prev;     // phase of the last accepted pixel
    phase_t w_phase;
    logic   w_accept;
    logic   w_frame_start;

    assign w_accept      = cke & valid;
    assign w_frame_start = line_first & pixel_first;

    always_comb begin
        w_phase = {r_prev[1], ~r_prev[0]};
        if (w_frame_start) begin
            w_phase = param_phase;
        end else if (pixel_first) begin
            w_phase = {~r_prev[1], r_held[0]};
        end
    end

    assign phase = w_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_held <= PHASE_R;
            r_prev <= PHASE_R;
        end else if (w_accept) begin
            r_prev <= w_phase;
            if (w_frame_start) begin
                r_held <= param_phase;
            end
        end
    end

endmodule

// File: rtl/jelly3_img_bayer_mosaic.sv
// ---------------------------------------------------------------------------
// jelly3_img_bayer_mosaic
//   Converts an RGB pixel stream into a Bayer raw stream: one raw sample
//   per accepted pixel (cke & in_valid), chosen from in_r/in_g/in_b by the
//   pixel's Bayer phase. Fixed latency of two cke-qualified cycles; the
//   valid and first flags travel with the data.
//
//   Stage 1 : phase tracking + component select
//   Stage 2 : optional black-level offset (saturating), otherwise a plain
//             register so latency does not depend on the build option.
//
//   Build option: define JELLY3_IMG_BAYER_MOSAIC_BLACK_EN to add
//   param_black to every sample in stage 2 with saturation at
//   2^DATA_BITS-1. Without it param_black is ignored.
//
// Ports
//   reset_n         in  async active-low reset
//   clk             in  clock, rising edge
//   cke             in  clock enable, freezes all state when 0
//   param_phase     in  phase of top-left pixel, sampled at frame start
//   param_black     in  black level (only with the build option)
//   in_line_first   in  frame start when set with in_pixel_first
//   in_pixel_first  in  first pixel of a line
//   in_valid        in  input pixel valid
//   in_r/in_g/in_b  in  RGB components
//   out_line_first  out delayed in_line_first
//   out_pixel_first out delayed in_pixel_first
//   out_valid       out delayed in_valid
//   out_phase       out Bayer phase of out_raw
//   out_raw         out Bayer raw sample
// ---------------------------------------------------------------------------
module jelly3_img_bayer_mosaic
    import jelly3_img_bayer_pkg::*;
#(
    parameter int  DATA_BITS = 10,
    parameter type data_t    = logic [DATA_BITS-1:0]
)(
    input  logic   reset_n,
    input  logic   clk,
    input  logic   cke,

    input  phase_t param_phase,
    input  data_t  param_black,

    input  logic   in_line_first,
    input  logic   in_pixel_first,
    input  logic   in_valid,
    input  data_t  in_r,
    input  data_t  in_g,
    input  data_t  in_b,

    output logic   out_line_first,
    output logic   out_pixel_first,
    output logic   out_valid,
    output phase_t out_phase,
    output data_t  out_raw
);

    // Pick the colour component sampled at a given Bayer site.
    function automatic data_t select_raw(
        input phase_t ph,
        input data_t  r,
        input data_t  g,
        input data_t  b
    );
        case (ph)
            PHASE_R: return r;
            PHASE_B: return b;
            default: return g;
        endcase
    endfunction

`ifdef JELLY3_IMG_BAYER_MOSAIC_BLACK_EN
    // Unsigned add with one guard bit; clamp to all-ones on carry out.
    function automatic data_t sat_add(input data_t a, input data_t b);
        logic [DATA_BITS:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[DATA_BITS]) begin
            return '1;
        end
        return data_t'(sum[DATA_BITS-1:0]);
    endfunction
`endif

    // ---- stage 0 : phase of the incoming pixel, component select ----------
    phase_t w_phase_p0;
    data_t  w_raw_p0;

    jelly3_img_bayer_phase_counter u_phase_counter (
        .reset_n     (reset_n),
        .clk         (clk),
        .cke         (cke),
        .valid       (in_valid),
        .line_first  (in_line_first),
        .pixel_first (in_pixel_first),
        .param_phase (param_phase),
        .phase       (w_phase_p0)
    );

    assign w_raw_p0 = select_raw(w_phase_p0, in_r, in_g, in_b);

    // ---- stage 1 : selected sample registered ------------------------------
    logic   r_vld_p1;
    logic   r_lf_p1;
    logic   r_pf_p1;
    phase_t r_phase_p1;
    data_t  r_raw_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1   <= 1'b0;
            r_lf_p1    <= 1'b0;
            r_pf_p1    <= 1'b0;
            r_phase_p1 <= PHASE_R;
            r_raw_p1   <= '0;
        end else if (cke) begin
            r_vld_p1   <= in_valid;
            r_lf_p1    <= in_line_first;
            r_pf_p1    <= in_pixel_first;
            r_phase_p1 <= w_phase_p0;
            r_raw_p1   <= w_raw_p0;
        end
    end

    // ---- stage 2 : black-level offset or plain delay -----------------------
    data_t w_raw_p1;

`ifdef JELLY3_IMG_BAYER_MOSAIC_BLACK_EN
    assign w_raw_p1 = sat_add(r_raw_p1, param_black);
`else
    logic w_unused_black;
    assign w_unused_black = ^param_black;
    assign w_raw_p1       = r_raw_p1;
`endif

    logic   r_vld_p2;
    logic   r_lf_p2;
    logic   r_pf_p2;
    phase_t r_phase_p2;
    data_t  r_raw_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p2   <= 1'b0;
            r_lf_p2    <= 1'b0;
            r_pf_p2    <= 1'b0;
            r_phase_p2 <= PHASE_R;
            r_raw_p2   <= '0;
        end else if (cke) begin
            r_vld_p2   <= r_vld_p1;
            r_lf_p2    <= r_lf_p1;
            r_pf_p2    <= r_pf_p1;
            r_phase_p2 <= r_phase_p1;
            r_raw_p2   <= w_raw_p1;
        end
    end

    assign out_valid       = r_vld_p2;
    assign out_line_first  = r_lf_p2;
    assign out_pixel_first = r_pf_p2;
    assign out_phase       = r_phase_p2;
    assign out_raw         = r_raw_p2;

endmodule

// File: tb/tb_jelly3_img_bayer_mosaic.sv
// ---------------------------------------------------------------------------
// tb_jelly3_img_bayer_mosaic
//   Randomized and directed stimulus against a frame/row/column model of
//   the Bayer pattern. Expected samples are queued at acceptance together
//   with the cke-cycle count and compared when they leave the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_jelly3_img_bayer_mosaic;

    localparam int DATA_BITS = 10;
    localparam int MAX_VAL   = (1 << DATA_BITS) - 1;

    logic                 reset_n;
    logic                 clk;
    logic                 cke;
    logic [1:0]           param_phase;
    logic [DATA_BITS-1:0] param_black;
    logic                 in_line_first;
    logic                 in_pixel_first;
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_r;
    logic [DATA_BITS-1:0] in_g;
    logic [DATA_BITS-1:0] in_b;
    logic                 out_line_first;
    logic                 out_pixel_first;
    logic                 out_valid;
    logic [1:0]           out_phase;
    logic [DATA_BITS-1:0] out_raw;

    jelly3_img_bayer_mosaic #(
        .DATA_BITS (DATA_BITS)
    ) u_dut (
        .reset_n         (reset_n),
        .clk             (clk),
        .cke             (cke),
        .param_phase     (param_phase),
        .param_black     (param_black),
        .in_line_first   (in_line_first),
        .in_pixel_first  (in_pixel_first),
        .in_valid        (in_valid),
        .in_r            (in_r),
        .in_g            (in_g),
        .in_b            (in_b),
        .out_line_first  (out_line_first),
        .out_pixel_first (out_pixel_first),
        .out_valid       (out_valid),
        .out_phase       (out_phase),
        .out_raw         (out_raw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---- reference model ---------------------------------------------------
    typedef struct {
        int       t;
        bit       lf;
        bit       pf;
        bit [1:0] ph;
        int       raw;
    } exp_t;

    exp_t     q[$];
    int       cke_cnt  = 0;
    bit       last_cke = 0;
    int       m_row    = 0;
    int       m_col    = 0;
    bit [1:0] m_base   = 2'b00;

    function automatic int model_raw(input bit [1:0] ph, input int r, input int g, input int b);
        int v;
        if (ph == 2'b00)      v = r;
        else if (ph == 2'b11) v = b;
        else                  v = g;
`ifdef JELLY3_IMG_BAYER_MOSAIC_BLACK_EN
        v = v + int'(param_black);
        if (v > MAX_VAL) v = MAX_VAL;
`endif
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_row    = 0;
        m_col    = 0;
        m_base   = 2'b00;
        last_cke = 0;
    endtask

    // Acceptance side: phase = frame phase XOR (row parity, column parity).
    always @(posedge clk) begin
        exp_t e;
        if (!reset_n) begin
            last_cke = 0;
        end else begin
            last_cke = cke;
            if (cke && in_valid) begin
                if (in_line_first && in_pixel_first) begin
                    m_base = param_phase;
                    m_row  = 0;
                    m_col  = 0;
                end else if (in_pixel_first) begin
                    m_row++;
                    m_col = 0;
                end else begin
                    m_col++;
                end
                e.t   = cke_cnt;
                e.lf  = in_line_first;
                e.pf  = in_pixel_first;
                e.ph  = m_base ^ {m_row[0], m_col[0]};
                e.raw = model_raw(e.ph, int'(in_r), int'(in_g), int'(in_b));
                q.push_back(e);
            end
            if (cke) cke_cnt++;
        end
    end

    // Output side: after every cke-qualified edge, out_valid must be set
    // exactly when the oldest pending sample is two cke cycles old.
    always @(negedge clk) begin
        bit   exp_v;
        exp_t e;
        if (reset_n && last_cke) begin
            exp_v = (q.size() > 0) && (cke_cnt - q[0].t == 2);
            check_val("out_valid", int'(out_valid), int'(exp_v));
            if (out_valid && exp_v) begin
                e = q.pop_front();
                check_val("out_raw",         int'(out_raw),         e.raw);
                check_val("out_phase",       int'(out_phase),       int'(e.ph));
                check_val("out_line_first",  int'(out_line_first),  int'(e.lf));
                check_val("out_pixel_first", int'(out_pixel_first), int'(e.pf));
            end
        end
    end

    // ---- stimulus ----------------------------------------------------------
    task automatic drive(input bit c, input bit v, input bit lf, input bit pf,
                         input int r, input int g, input int b);
        @(negedge clk);
        cke            = c;
        in_valid       = v;
        in_line_first  = lf;
        in_pixel_first = pf;
        in_r           = DATA_BITS'(r);
        in_g           = DATA_BITS'(g);
        in_b           = DATA_BITS'(b);
    endtask

    // Idle slots: bubbles (cke=1, valid=0) or stalls (cke=0, random inputs).
    task automatic gaps(input int bubble_pct, input int stall_pct);
        while (int'($urandom_range(99)) < bubble_pct + stall_pct) begin
            if (int'($urandom_range(bubble_pct + stall_pct - 1)) < bubble_pct)
                drive(1'b1, 1'b0, 1'($urandom), 1'($urandom), $urandom_range(MAX_VAL), $urandom_range(MAX_VAL), $urandom_range(MAX_VAL));
            else
                drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(MAX_VAL), $urandom_range(MAX_VAL), $urandom_range(MAX_VAL));
        end
    endtask

    task automatic send_frame(input int w, input int h, input bit [1:0] ph,
                              input bit rnd, input int r0, input int g0, input int b0,
                              input int bubble_pct, input int stall_pct, input bit chg);
        int r, g, b;
        param_phase = ph;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (bubble_pct + stall_pct > 0) gaps(bubble_pct, stall_pct);
                r = rnd ? int'($urandom_range(MAX_VAL)) : r0;
                g = rnd ? int'($urandom_range(MAX_VAL)) : g0;
                b = rnd ? int'($urandom_range(MAX_VAL)) : b0;
                drive(1'b1, 1'b1, (x == 0) && (y == 0), (x == 0), r, g, b);
                if (chg && x == 0 && y == 0) begin
                    @(negedge clk);
                    param_phase = 2'($urandom);
                    in_valid    = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_valid"}, int'(out_valid),       0);
        check_val({tag, "_raw"},   int'(out_raw),         0);
        check_val({tag, "_phase"}, int'(out_phase),       0);
        check_val({tag, "_lf"},    int'(out_line_first),  0);
        check_val({tag, "_pf"},    int'(out_pixel_first), 0);
    endtask

    initial begin
        reset_n        = 1'b0;
        cke            = 1'b1;
        param_phase    = 2'b00;
        param_black    = DATA_BITS'(100);
        in_line_first  = 1'b0;
        in_pixel_first = 1'b0;
        in_valid       = 1'b0;
        in_r           = '0;
        in_g           = '0;
        in_b           = '0;

        #1;
        check_cleared("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // constant colours, phase 00 and 11, two frames each
        send_frame(4, 4, 2'b00, 1'b0, 100, 200, 300, 0, 0, 1'b0);
        send_frame(4, 4, 2'b00, 1'b0, 100, 200, 300, 0, 0, 1'b0);
        send_frame(4, 4, 2'b11, 1'b0, 100, 200, 300, 0, 0, 1'b0);
        // bubbles and stalls inside rows
        send_frame(4, 4, 2'b00, 1'b0, 100, 200, 300, 25, 25, 1'b0);
        // param_phase changed mid-frame, next frame uses 01
        send_frame(4, 4, 2'b00, 1'b0, 100, 200, 300, 0, 0, 1'b1);
        send_frame(4, 4, 2'b01, 1'b0, 100, 200, 300, 0, 0, 1'b0);
        // near-full-scale red for the black-level clamp
        send_frame(4, 2, 2'b00, 1'b0, 1000, 200, 300, 0, 0, 1'b0);
        idle(3);

        // asynchronous reset in the middle of a row
        send_frame(4, 1, 2'b10, 1'b0, 100, 200, 300, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_cleared("async_rst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        // rest of a row without a frame start, then a clean frame
        for (int x = 0; x < 3; x++) drive(1'b1, 1'b1, 1'b0, 1'b0, 100, 200, 300);
        send_frame(4, 4, 2'b00, 1'b0, 100, 200, 300, 0, 0, 1'b0);

        // random frames
        for (int f = 0; f < 24; f++) begin
            send_frame(int'($urandom_range(8, 1)), int'($urandom_range(6, 1)), 2'($urandom),
                       1'b1, 0, 0, 0, int'($urandom_range(30)), int'($urandom_range(30)),
                       1'($urandom));
        end

        idle(6);
        check_val("drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jelly3_img_bayer_mosaic.md
JELLY3_IMG_BAYER_MOSAIC -- requirements
Module: jelly3_img_bayer_mosaic

Interface
REQ-001 SHALL have parameter DATA_BITS, default 10, pixel component width.
REQ-002 SHALL have parameter data_t, default logic [DATA_BITS-1:0], pixel component type (unsigned).
REQ-003 SHALL have localparam phase_t = logic [1:0], Bayer phase (bit0 = column parity, bit1 = row parity).
REQ-004 SHALL have ports: reset_n  in  1  asynchronous active-low reset; clk  in  1  clock, rising edge; cke  in  1  clock enable, all state frozen when 0.
REQ-005 SHALL have ports: param_phase  in  phase_t  phase of top-left pixel; param_black  in  data_t  black level (used only with macro).
REQ-006 SHALL have ports: in_line_first, in_pixel_first, in_valid  in  1 each; in_r, in_g, in_b  in  data_t.
REQ-007 SHALL have ports: out_line_first, out_pixel_first, out_valid  out  1 each; out_phase  out  phase_t; out_raw  out  data_t.

Function
REQ-008 SHALL produce one Bayer sample per accepted pixel; accepted = cke & in_valid.
REQ-009 SHALL have fixed latency 2 cke-qualified cycles, with or without the macro; in_valid/first flags delayed identically.
REQ-010 SHALL treat in_line_first & in_pixel_first on an accepted pixel as frame start: latch param_phase into a held register; that pixel's phase = param_phase.
REQ-011 SHALL, on an accepted in_pixel_first without in_line_first: phase bit0 = held bit0, phase bit1 = inverted previous bit1.
REQ-012 SHALL otherwise, per accepted pixel, invert phase bit0 and keep bit1.
REQ-013 SHALL not advance phase on cycles with in_valid = 0 or cke = 0 (bubbles tolerated anywhere).
REQ-014 SHALL select: phase 00 -> in_r; 01 -> in_g; 10 -> in_g; 11 -> in_b (00 = R site, 11 = B site, 01/10 = G sites in R/B rows).
REQ-015 SHALL ignore param_phase changes except at frame start.
REQ-016 SHALL output data of non-valid slots as don't-care but SHALL keep out_valid = 0 for them.
REQ-017 SHALL, before any frame start since reset, use held phase 00.

Reset
REQ-018 SHALL on reset_n = 0 asynchronously clear all pipeline registers: out_valid, out_line_first, out_pixel_first = 0, out_raw = 0, out_phase = 00, held phase = 00.
REQ-019 SHALL resume on reset release mid-line with phase per REQ-017 until next frame start; no output glitch beyond cleared values.

Configuration
REQ-020 SHALL support macro JELLY3_IMG_BAYER_MOSAIC_BLACK_EN.
REQ-021 SHALL with macro defined: stage 2 computes selected + param_black in DATA_BITS+1 bits, saturating at 2^DATA_BITS-1 (e.g. 1000+100 -> 1023 at 10 bits).
REQ-022 SHALL without macro: stage 2 is a pure register, param_black unused, latency unchanged.

Structure
REQ-023 SHALL place phase_t and phase constants (PHASE_R=00, PHASE_GR=01, PHASE_GB=10, PHASE_B=11) in shared package jelly3_img_bayer_pkg, also usable by demosaic blocks.
REQ-024 SHALL implement phase tracking as sub-module jelly3_img_bayer_phase_counter (inputs cke, valid, line_first, pixel_first, param_phase; output phase), reusable by the demosaic side.

Verification
REQ-025 SHALL cover: 4x4 frame, param_phase=00, r=100 g=200 b=300 constant -> out_raw rows 100,200,100,200 / 200,300,200,300, repeating, 2 cycles after input.
REQ-026 SHALL cover: param_phase=11 same frame -> first row 300,200,300,200; second row 200,100,200,100.
REQ-027 SHALL cover: in_valid=0 bubble and cke=0 stall inserted mid-row -> output sequence identical to REQ-025, out_valid gaps match.
REQ-028 SHALL cover: param_phase changed 00->01 mid-frame -> no effect until next frame start; next frame first pixel outputs g.
REQ-029 SHALL cover: reset_n pulsed low mid-row -> out_valid=0, out_raw=0 immediately (async), next frame correct.
REQ-030 SHALL cover: macro defined, param_black=100, r=1000 at R site -> out_raw=1023; g=200 -> 300; macro undefined -> 1000 and 200.
